// File: rtl/full_adder_pkg.sv
// Shared width limits for the registered ripple-carry adder.
package full_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 1;
    localparam int unsigned WIDTH_MAX     = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// One combinational full-adder bit: s = a ^ b ^ ci, co = majority(a, b, ci).
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder followed by a single output register stage.
import full_adder_pkg::*;

module full_adder #(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             out_valid
);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("full_adder: WIDTH out of range");
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    assign carry[0] = Cin;

    // Ripple chain: carry[i+1] feeds the next bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_d[i]),
            .co (carry[i+1])
        );
    end

    // Result holds while idle; valid pulses once per accepted operand set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= carry[WIDTH];
            end
        end
    end

    assign sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Randomized and directed checks of full_adder at WIDTH 1, 4 and 8 against an arithmetic model.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a1 = '0, b1 = '0, c1 = 1'b0, v1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       c4 = 1'b0, v4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0, v8 = 1'b0;

    logic       s1, co1, ov1;
    logic [3:0] s4;
    logic       co4, ov4;
    logic [7:0] s8;
    logic       co8, ov8;

    logic       m1_s, m1_c, m1_v;
    logic [3:0] m4_s;
    logic       m4_c, m4_v;
    logic [7:0] m8_s;
    logic       m8_c, m8_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .Cin(c1), .in_valid(v1),
        .sum(s1), .Cout(co1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .Cin(c4), .in_valid(v4),
        .sum(s4), .Cout(co4), .out_valid(ov4)
    );
    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .Cin(c8), .in_valid(v8),
        .sum(s8), .Cout(co8), .out_valid(ov8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m1_s = '0; m1_c = 1'b0; m1_v = 1'b0;
        m4_s = '0; m4_c = 1'b0; m4_v = 1'b0;
        m8_s = '0; m8_c = 1'b0; m8_v = 1'b0;
    endtask

    task automatic check_all();
        check("w1_sum", 64'(s1), 64'(m1_s));
        check("w1_cout", 64'(co1), 64'(m1_c));
        check("w1_valid", 64'(ov1), 64'(m1_v));
        check("w4_sum", 64'(s4), 64'(m4_s));
        check("w4_cout", 64'(co4), 64'(m4_c));
        check("w4_valid", 64'(ov4), 64'(m4_v));
        check("w8_sum", 64'(s8), 64'(m8_s));
        check("w8_cout", 64'(co8), 64'(m8_c));
        check("w8_valid", 64'(ov8), 64'(m8_v));
    endtask

    // Advance one edge, update the model from the values present at that edge, then compare.
    task automatic tick();
        logic [64:0] r;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m1_v = v1;
            if (v1) begin
                r = 65'(a1) + 65'(b1) + 65'(c1);
                m1_s = r[0];
                m1_c = r[1];
            end
            m4_v = v4;
            if (v4) begin
                r = 65'(a4) + 65'(b4) + 65'(c4);
                m4_s = r[3:0];
                m4_c = r[4];
            end
            m8_v = v8;
            if (v8) begin
                r = 65'(a8) + 65'(b8) + 65'(c8);
                m8_s = r[7:0];
                m8_c = r[8];
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle_all();
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    endtask

    initial begin
        logic [2:0] combo;
        model_reset();

        // Reset state held across edges with valid inputs present.
        v1 = 1'b1; v4 = 1'b1; v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        tick();
        tick();
        #2 rst = 1'b0;
        idle_all();
        tick();

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            a1 = combo[2]; b1 = combo[1]; c1 = combo[0]; v1 = 1'b1;
            tick();
            if (combo == 3'b001) begin
                check("w1_001_sum", 64'(s1), 64'd1);
                check("w1_001_cout", 64'(co1), 64'd0);
            end
            if (combo == 3'b111) begin
                check("w1_111_sum", 64'(s1), 64'd1);
                check("w1_111_cout", 64'(co1), 64'd1);
            end
        end
        idle_all();

        // WIDTH=4 wrap-around.
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; v4 = 1'b1;
        tick();
        check("w4_wrap_sum", 64'(s4), 64'h0);
        check("w4_wrap_cout", 64'(co4), 64'd1);
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        tick();
        check("w4_full_sum", 64'(s4), 64'hF);
        check("w4_full_cout", 64'(co4), 64'd1);

        // Hold while in_valid is low.
        a4 = 4'h1; b4 = 4'h0; c4 = 1'b0;
        tick();
        a4 = 4'h1; b4 = 4'h1; v4 = 1'b0;
        tick();
        tick();
        check("w4_hold_sum", 64'(s4), 64'd1);
        check("w4_hold_cout", 64'(co4), 64'd0);
        check("w4_hold_valid", 64'(ov4), 64'd0);

        // Back-to-back accepted inputs at WIDTH=8.
        for (int i = 0; i < 3; i++) begin
            a8 = 8'(8'h70 + 8'(i * 8'h20)); b8 = 8'(8'h55 * i); c8 = 1'(i); v8 = 1'b1;
            tick();
            check("w8_b2b_valid", 64'(ov8), 64'd1);
        end

        // Reset between edges while out_valid is high.
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_sum", 64'(s8), 64'd0);
        check("rst_async_valid", 64'(ov8), 64'd0);
        check_all();
        #1 rst = 1'b0;
        idle_all();
        tick();
        check("rst_no_pulse", 64'(ov8), 64'd0);

        // First edge after reset is accepted normally.
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b1; v8 = 1'b1;
        tick();
        check("post_rst_sum", 64'(s8), 64'h47);

        // Random vectors at WIDTH=8.
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            v8 = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_full_adder
